dec_key_sched: RTL
==================

Name: dec_key_sched

Overview:
- Controller that sequences the AES-128 decryption key path.
- Collects the cipher key as eight 16-bit words (MS word first) and drives an external key-expansion round unit through a req/ack handshake.
- Buffers all 11 round keys, then serves them to the inverse-round datapath in reverse order (round 10 down to 0) over a valid/ready handshake.
- Sits between the key word input and the decryption round pipeline.

Parameters:
- NWORDS, 8, number of 16-bit key words per key (fixed 128-bit key).
- NROUNDS, 10, number of AES rounds; the buffer holds NROUNDS+1 keys.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- key_load_start  in  1  pulse; begins a new key load.
- key_word  in  16  key word.
- key_word_valid  in  1  key_word is accepted this cycle when in LOAD.
- exp_req  out  1  expansion request; held high until exp_ack.
- exp_prev  out  128  previous round key presented to the expansion unit.
- exp_round  out  4  round being generated (1..10), used by the expansion unit for rcon.
- exp_ack  in  1  exp_rk valid; completes the request.
- exp_rk  in  128  round key returned by the expansion unit.
- dec_start  in  1  pulse; begins serving round keys.
- rk_out  out  128  round key presented to the datapath.
- rk_round  out  4  round index of rk_out.
- rk_valid  out  1  rk_out is valid.
- rk_ready  in  1  datapath accepts rk_out.
- rk_last  out  1  high with rk_valid when rk_round==0.
- key_ready  out  1  full schedule present; dec_start will be accepted.
- busy  out  1  high in LOAD, EXPAND, DECRYPT.

Behaviour:
- Reset: state=IDLE; every output is 0 (exp_req, exp_prev, exp_round, rk_out, rk_round, rk_valid, rk_last, key_ready, busy). Word and round counters are 0. Buffer contents are don't-care, but are never served while key_ready=0.
- FSM states: IDLE, LOAD, EXPAND, READY, DECRYPT.
- IDLE:
  - key_load_start -> LOAD; word counter=0; key_ready=0.
  - Any other input is ignored.
- LOAD:
  - Each cycle with key_word_valid=1 shifts the key register left by 16 and inserts key_word in bits [15:0]; the counter increments.
  - The first word ends up in bits [127:112].
  - On the cycle the 8th word is accepted: buf[0] is loaded with the key, the next state is EXPAND, and exp_round=1.
  - key_load_start in LOAD restarts the load with counter=0; partial words are discarded.
- EXPAND:
  - exp_req=1 with exp_prev=buf[exp_round-1].
  - On exp_ack: buf[exp_round] is written from exp_rk. Then:
    - if exp_round<10: exp_round increments; exp_req stays high next cycle.
    - if exp_round==10: exp_req drops, key_ready rises, next state is READY.
  - exp_ack while exp_req=0 is ignored.
  - key_load_start and dec_start are ignored.
  - Latency from the last key word to key_ready is 10 ack cycles plus 1.
- READY:
  - dec_start -> DECRYPT; rk_round=10; rk_valid=1 from the next cycle.
  - key_load_start -> LOAD; key_ready=0.
  - If both pulse in the same cycle, key_load_start wins.
- DECRYPT:
  - rk_out=buf[rk_round] is registered.
  - A transfer occurs when rk_valid & rk_ready.
  - After a transfer with rk_round>0: rk_round decrements; the next key is valid the following cycle with no bubble (rk_valid stays 1).
  - After the transfer with rk_round==0: rk_valid=0, next state is READY, key_ready stays 1, and keys are retained for further blocks.
  - rk_out and rk_round must hold stable while rk_valid=1 and rk_ready=0.
  - key_load_start and dec_start are ignored.
- busy is high in LOAD, EXPAND and DECRYPT, and low in IDLE and READY.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. Any in-flight exp_ack or rk_ready is ignored.
- Widths: rk_round and exp_round are 4-bit; values above 10 are never produced.

Optional Feature:
- KEY_ZEROIZE_EN defined:
  - Adds input key_clear (1 bit).
  - key_clear=1 in any state clears all 11 buffer entries and the load shift register to 0 in one cycle, forces IDLE, and zeroes all outputs.
  - key_clear has priority over every input except rst.
- KEY_ZEROIZE_EN undefined: the port is absent, and key material persists until overwritten.

Test Plan:
- Reset, then load words 0x2B7E,0x1516,0x28AE,0xD2A6,0xABF7,0x1588,0x09CF,0x4F3C with a model expansion unit acking 1 cycle after req -> exp_prev for round 1 = 0x2B7E151628AED2A6ABF7158809CF4F3C; key_ready=1 after the 10th ack.
- From READY, dec_start with rk_ready=1 constantly -> rk_round sequence 10..0 on 11 consecutive cycles; rk_last only with round 0; round 10 key = 0xD014F9A8C9EE2589E13F0CC8B6630CA6.
- During DECRYPT, rk_ready toggles 1,0,0,1 -> rk_out and rk_round hold during stalls; no round is skipped or repeated.
- key_word_valid gaps during LOAD, and a key_load_start after 5 words -> only the 8 words after the restart form the key.
- rst asserted mid-EXPAND (round 4) -> IDLE next cycle, exp_req=0, key_ready=0; a subsequent dec_start is ignored.
- With KEY_ZEROIZE_EN defined: key_clear in READY -> IDLE; after reload of all-zero words, round 0 key = 0.

Source files
------------

// File: rtl/dec_key_sched.sv
// ---------------------------------------------------------------------------
// dec_key_sched
// AES-128 decryption key-path sequencer. Collects a 128-bit cipher key as
// eight 16-bit words (MS word first), drives an external key-expansion round
// unit through a req/ack handshake to build all 11 round keys, then serves
// those keys to the inverse-round datapath from round 10 down to round 0
// over a valid/ready handshake.
//
// Optional build macro:
//   KEY_ZEROIZE_EN - adds input key_clear, which wipes the round-key buffer
//                    and load shift register in one cycle and forces IDLE.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   key_clear         (KEY_ZEROIZE_EN only) zeroize key material
//   key_load_start    pulse, begin a new key load
//   key_word[15:0]    key word, accepted in LOAD when key_word_valid=1
//   key_word_valid    key word qualifier
//   exp_req           expansion request, held until exp_ack
//   exp_prev[127:0]   previous round key for the expansion unit
//   exp_round[3:0]    round being generated (1..10)
//   exp_ack           exp_rk valid, completes the request
//   exp_rk[127:0]     round key returned by the expansion unit
//   dec_start         pulse, begin serving round keys
//   rk_out[127:0]     round key to the datapath
//   rk_round[3:0]     round index of rk_out
//   rk_valid          rk_out valid
//   rk_ready          datapath accepts rk_out
//   rk_last           rk_valid with rk_round==0
//   key_ready         full schedule present
//   busy              high in LOAD, EXPAND, DECRYPT
// ---------------------------------------------------------------------------
module dec_key_sched #(
    parameter int unsigned NWORDS  = 8,
    parameter int unsigned NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
`ifdef KEY_ZEROIZE_EN
    input  logic         key_clear,
`endif
    input  logic         key_load_start,
    input  logic [15:0]  key_word,
    input  logic         key_word_valid,
    output logic         exp_req,
    output logic [127:0] exp_prev,
    output logic [3:0]   exp_round,
    input  logic         exp_ack,
    input  logic [127:0] exp_rk,
    input  logic         dec_start,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         key_ready,
    output logic         busy
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned KEY_W  = NWORDS * WORD_W;
    localparam int unsigned SR_W   = KEY_W - WORD_W;
    localparam int unsigned CNT_W  = $clog2(NWORDS);
    localparam int unsigned RND_W  = 4;
    localparam int          NKEYS  = int'(NROUNDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_READY,
        S_DECRYPT
    } state_e;

    state_e               state_q;
    logic [SR_W-1:0]      key_sr_q;
    logic [CNT_W-1:0]     wcnt_q;
    logic                 exp_req_q;
    logic [KEY_W-1:0]     exp_prev_q;
    logic [RND_W-1:0]     exp_round_q;
    logic [KEY_W-1:0]     rk_out_q;
    logic [RND_W-1:0]     rk_round_q;
    logic                 rk_valid_q;
    logic                 rk_last_q;
    logic                 key_ready_q;
    logic                 busy_q;
    logic [KEY_W-1:0]     rk_buf_q [NKEYS];

    logic                 clear_c;
    logic [KEY_W-1:0]     key_full_c;
    logic                 load_done_c;
    logic                 exp_done_c;
    logic                 xfer_c;
    logic [RND_W-1:0]     rd_idx_c;

`ifdef KEY_ZEROIZE_EN
    assign clear_c = key_clear;
`else
    assign clear_c = 1'b0;
`endif

    // Shift register only keeps the first seven words; the eighth is
    // appended combinationally so the full key lands in buf[0] directly.
    assign key_full_c = {key_sr_q, key_word};

    // Write strobes shared by the FSM and the round-key buffer.
    always_comb begin
        load_done_c = 1'b0;
        exp_done_c  = 1'b0;
        xfer_c      = 1'b0;
        rd_idx_c    = rk_round_q - RND_W'(1);
        if (!rst && !clear_c) begin
            load_done_c = (state_q == S_LOAD) && !key_load_start && key_word_valid
                          && (wcnt_q == CNT_W'(NWORDS - 1));
            exp_done_c  = (state_q == S_EXPAND) && exp_req_q && exp_ack;
            xfer_c      = (state_q == S_DECRYPT) && rk_valid_q && rk_ready;
        end
    end

    // Round-key storage; contents are meaningless until key_ready is set.
    always_ff @(posedge clk) begin
        if (clear_c) begin
            for (int i = 0; i < NKEYS; i++) begin
                rk_buf_q[i] <= '0;
            end
        end else begin
            if (load_done_c) begin
                rk_buf_q[0] <= key_full_c;
            end
            if (exp_done_c) begin
                rk_buf_q[exp_round_q] <= exp_rk;
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            state_q     <= S_IDLE;
            key_sr_q    <= '0;
            wcnt_q      <= '0;
            exp_req_q   <= 1'b0;
            exp_prev_q  <= '0;
            exp_round_q <= '0;
            rk_out_q    <= '0;
            rk_round_q  <= '0;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_load_start) begin
                        state_q     <= S_LOAD;
                        wcnt_q      <= '0;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (key_load_start) begin
                        // Restart: any partial words are overwritten by the next eight.
                        wcnt_q <= '0;
                    end else if (key_word_valid) begin
                        key_sr_q <= key_full_c[SR_W-1:0];
                        if (wcnt_q == CNT_W'(NWORDS - 1)) begin
                            state_q     <= S_EXPAND;
                            wcnt_q      <= '0;
                            exp_req_q   <= 1'b1;
                            exp_prev_q  <= key_full_c;
                            exp_round_q <= RND_W'(1);
                        end else begin
                            wcnt_q <= wcnt_q + CNT_W'(1);
                        end
                    end
                end

                S_EXPAND: begin
                    if (exp_req_q && exp_ack) begin
                        if (exp_round_q == RND_W'(NROUNDS)) begin
                            state_q     <= S_READY;
                            exp_req_q   <= 1'b0;
                            exp_round_q <= '0;
                            key_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            // The key just returned is the seed for the next round.
                            exp_prev_q  <= exp_rk;
                            exp_round_q <= exp_round_q + RND_W'(1);
                        end
                    end
                end

                S_READY: begin
                    if (key_load_start) begin
                        state_q     <= S_LOAD;
                        wcnt_q      <= '0;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else if (dec_start) begin
                        state_q    <= S_DECRYPT;
                        busy_q     <= 1'b1;
                        rk_valid_q <= 1'b1;
                        rk_round_q <= RND_W'(NROUNDS);
                        rk_out_q   <= rk_buf_q[NROUNDS];
                        rk_last_q  <= 1'b0;
                    end
                end

                S_DECRYPT: begin
                    if (xfer_c) begin
                        if (rk_round_q == '0) begin
                            state_q    <= S_READY;
                            busy_q     <= 1'b0;
                            rk_valid_q <= 1'b0;
                            rk_last_q  <= 1'b0;
                            rk_out_q   <= '0;
                        end else begin
                            // Next key is presented right away, no bubble.
                            rk_round_q <= rd_idx_c;
                            rk_out_q   <= rk_buf_q[rd_idx_c];
                            rk_last_q  <= (rk_round_q == RND_W'(1));
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign exp_req   = exp_req_q;
    assign exp_prev  = exp_prev_q;
    assign exp_round = exp_round_q;
    assign rk_out    = rk_out_q;
    assign rk_round  = rk_round_q;
    assign rk_valid  = rk_valid_q;
    assign rk_last   = rk_last_q;
    assign key_ready = key_ready_q;
    assign busy      = busy_q;

endmodule
